// File: rtl/dma_pkg.sv
// dma_pkg
//   Shared types for the DMA descriptor queue slice.
//   - DMA_ADDR_W / DMA_LEN_W : widths of the descriptor fields. The queue's
//     ADDR_W / LEN_W parameters must match these, because the descriptor struct
//     below is built from them.
//   - dma_desc_t   : one {src, dst, len} descriptor as stored in the FIFO.
//   - disp_state_t : dispatcher states.
//   - desc_misaligned() : true when either byte address is not word aligned.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  len;
  } dma_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } disp_state_t;

  // The DMA steps addresses by 4, so both low address bits must be zero.
  function automatic logic desc_misaligned(input dma_desc_t d);
    return (d.src[1:0] != 2'b00) || (d.dst[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo
//   Synchronous FIFO of dma_desc_t descriptors. Read data is the current head,
//   combinationally; a pop just advances the read pointer. There is no bypass, so
//   a descriptor written at one edge becomes visible at the head only afterwards.
// Ports
//   clk, rst            : clock, synchronous active-high reset (flushes pointers)
//   push, push_desc     : write request and data; ignored while full
//   pop                 : advance head; ignored while empty
//   head_desc           : descriptor at the head
//   count, full, empty  : occupancy status
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  dma_desc_t                push_desc,
  input  logic                     pop,
  output dma_desc_t                head_desc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  dma_desc_t      mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_desc = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_desc;
  end

endmodule

// File: rtl/dma_desc_queue.sv
// dma_desc_queue
//   Descriptor queue and dispatcher in front of simple_dma_controller. Buffers
//   host descriptors, drops ones the DMA cannot run (zero length, unaligned
//   address) with sticky error flags, and hands the rest to the DMA one at a time:
//   one-cycle dma_start with operands held stable, then wait for dma_done.
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   desc_valid/desc_ready, desc_*    : host descriptor push handshake
//   en                               : allow new dispatches (in-flight job always finishes)
//   err_clr                          : clears err_zero_len / err_misalign
//   dma_start, dma_*_addr, dma_length: command to the DMA
//   dma_busy, dma_done               : DMA status (only dma_done is acted on)
//   q_count, q_full, q_empty         : FIFO status
//   active                           : a job is being issued or is in flight
//   cmpl_count, irq                  : completion counter (wraps) and per-job pulse
//   err_zero_len, err_misalign       : sticky drop flags
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [ADDR_W-1:0]      desc_src,
  input  logic [ADDR_W-1:0]      desc_dst,
  input  logic [LEN_W-1:0]       desc_len,
  input  logic                   en,
  input  logic                   err_clr,
  output logic                   dma_start,
  output logic [ADDR_W-1:0]      dma_src_addr,
  output logic [ADDR_W-1:0]      dma_dst_addr,
  output logic [LEN_W-1:0]       dma_length,
  input  logic                   dma_busy,
  input  logic                   dma_done,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   q_empty,
  output logic                   active,
  output logic [15:0]            cmpl_count,
  output logic                   irq,
  output logic                   err_zero_len,
  output logic                   err_misalign
);

  disp_state_t state;
  disp_state_t state_nxt;
  dma_desc_t   push_desc;
  dma_desc_t   head_desc;
  logic        pop;
  logic        head_zero_len;
  logic        head_misaligned;
  logic        head_bad;
  logic        load;
  logic        unused_busy;

  // Completion is signalled by dma_done alone; busy is informational here.
  assign unused_busy = dma_busy;

  assign push_desc  = '{src: desc_src, dst: desc_dst, len: desc_len};
  assign desc_ready = !q_full;

  dma_desc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (desc_valid),
    .push_desc(push_desc),
    .pop      (pop),
    .head_desc(head_desc),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Every head looked at in IDLE is popped, whether it is dispatched or dropped,
  // so a bad descriptor costs exactly one cycle.
  assign pop             = (state == IDLE) && en && !q_empty;
  assign head_zero_len   = (head_desc.len == '0);
  assign head_misaligned = desc_misaligned(head_desc);
  assign head_bad        = head_zero_len || head_misaligned;
  assign load            = pop && !head_bad;

  // Dispatcher state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: ISSUE lasts exactly one cycle; WAIT_DONE leaves on dma_done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (load)     state_nxt = ISSUE;
      ISSUE:                   state_nxt = WAIT_DONE;
      WAIT_DONE: if (dma_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state.
  always_comb begin
    dma_start = (state == ISSUE);
    active    = (state != IDLE);
  end

  // Operand registers are loaded only when a good descriptor is popped, so they
  // stay stable from one ISSUE until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_src_addr <= '0;
      dma_dst_addr <= '0;
      dma_length   <= '0;
    end else if (load) begin
      dma_src_addr <= head_desc.src;
      dma_dst_addr <= head_desc.dst;
      dma_length   <= head_desc.len;
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_zero_len <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      err_zero_len <= (err_zero_len && !err_clr) || (pop && head_zero_len);
      err_misalign <= (err_misalign && !err_clr) || (pop && head_misaligned);
    end
  end

  // Completion counter and irq only respond to dma_done while a job is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmpl_count <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (state == WAIT_DONE && dma_done) begin
        cmpl_count <= cmpl_count + 16'd1;
        irq        <= 1'b1;
      end
    end
  end

endmodule
